// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and constants for the encoder symbol scheduler
package enc_pkg;

    localparam logic [1:0] GEN4     = 2'd0;
    localparam logic [1:0] GEN3     = 2'd1;
    localparam logic [1:0] GEN2     = 2'd2;
    localparam logic [1:0] GEN_RSVD = 2'd3;

    localparam logic [3:0] DEF_TL_DSEL   = 4'd8;
    localparam logic [3:0] DEF_IDLE_DSEL = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    // Bytes per symbol; the reserved code never reaches RUN, so its value is unused.
    function automatic logic [4:0] sym_bytes(input logic [1:0] gen);
        case (gen)
            GEN3:    sym_bytes = 5'd16;
            GEN2:    sym_bytes = 5'd8;
            default: sym_bytes = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/enc_sym_arb.sv
// rtl/enc_sym_arb.sv - OS/TL grant decision with OS run-length fairness counter
module enc_sym_arb
    import enc_pkg::*;
#(
    parameter int MAX_OS_RUN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic os_avail,
    input  logic tl_avail,
    input  logic take,
    output logic grant_valid,
    output logic grant_tl
);

    localparam logic [3:0] MAX_RUN = 4'(MAX_OS_RUN);

    logic [3:0] os_run;

    // OS wins ties until it has had MAX_RUN symbols in a row.
    always_comb begin
        grant_valid = os_avail | tl_avail;
        grant_tl    = tl_avail & (~os_avail | (os_run == MAX_RUN));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            os_run <= 4'd0;
        end else if (take) begin
            if (grant_tl) begin
                os_run <= 4'd0;
            end else if (os_run != MAX_RUN) begin
                os_run <= os_run + 4'd1;
            end
        end
    end

endmodule

// File: rtl/enc_sym_scheduler.sv
// rtl/enc_sym_scheduler.sv - arbitrates OS and TL symbol sources onto the two-lane encoder
module enc_sym_scheduler
    import enc_pkg::*;
#(
    parameter int         MAX_OS_RUN = 4,
    parameter logic [3:0] TL_DSEL    = DEF_TL_DSEL,
    parameter logic [3:0] IDLE_DSEL  = DEF_IDLE_DSEL
) (
    input  logic       enc_clk,
    input  logic       rst,
    input  logic       cfg_en,
    input  logic [1:0] gen_speed_cfg,
    input  logic       os_sym_avail,
    input  logic [3:0] os_type,
    input  logic [7:0] os_lane_0,
    input  logic [7:0] os_lane_1,
    output logic       os_rd,
    input  logic       tl_sym_avail,
    input  logic [7:0] tl_lane_0,
    input  logic [7:0] tl_lane_1,
    output logic       tl_rd,
    output logic [7:0] lane_0_tx,
    output logic [7:0] lane_1_tx,
    output logic [3:0] d_sel,
    output logic [1:0] gen_speed,
    output logic       enable,
    output logic       sym_start,
    output logic       busy
);

    state_t     state;
    logic [3:0] byte_cnt;
    logic       cur_tl;

    logic       idle;
    logic       last;
    logic       grant_now;
    logic       pop;
    logic       pop_tl;
    logic       grant_valid;
    logic       grant_tl;
    logic [1:0] cur_gen;
    logic [3:0] cnt_now;

    enc_sym_arb #(
        .MAX_OS_RUN(MAX_OS_RUN)
    ) u_arb (
        .clk        (enc_clk),
        .rst        (rst),
        .os_avail   (os_sym_avail),
        .tl_avail   (tl_sym_avail),
        .take       (grant_now),
        .grant_valid(grant_valid),
        .grant_tl   (grant_tl)
    );

    // A grant always coincides with popping byte 0, whether from IDLE or from
    // the cycle after a boundary; an IDLE grant sizes its symbol from the cfg
    // value being latched in that same cycle.
    always_comb begin
        idle      = (state == ST_IDLE);
        cur_gen   = idle ? gen_speed_cfg : gen_speed;
        cnt_now   = idle ? 4'd0 : byte_cnt;
        last      = ({1'b0, cnt_now} == (sym_bytes(cur_gen) - 5'd1));
        grant_now = rst && grant_valid &&
                    ((idle && cfg_en && (gen_speed_cfg != GEN_RSVD)) ||
                     ((state == ST_RUN) && (byte_cnt == 4'd0)));
        pop       = grant_now || (rst && (state == ST_RUN) && (byte_cnt != 4'd0));
        pop_tl    = grant_now ? grant_tl : cur_tl;
        os_rd     = pop && !pop_tl;
        tl_rd     = pop && pop_tl;
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge enc_clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            byte_cnt  <= 4'd0;
            cur_tl    <= 1'b0;
            lane_0_tx <= 8'd0;
            lane_1_tx <= 8'd0;
            d_sel     <= IDLE_DSEL;
            gen_speed <= GEN4;
            enable    <= 1'b0;
            sym_start <= 1'b0;
        end else if (pop) begin
            lane_0_tx <= pop_tl ? tl_lane_0 : os_lane_0;
            lane_1_tx <= pop_tl ? tl_lane_1 : os_lane_1;
            enable    <= 1'b1;
            sym_start <= (cnt_now == 4'd0);
            if (grant_now) begin
                d_sel  <= grant_tl ? TL_DSEL : os_type;
                cur_tl <= grant_tl;
            end
            if (idle) begin
                gen_speed <= gen_speed_cfg;
            end
            byte_cnt <= last ? 4'd0 : cnt_now + 4'd1;
            state    <= (last && !(cfg_en && grant_valid)) ? ST_FLUSH : ST_RUN;
        end else if (idle) begin
            lane_0_tx <= 8'd0;
            lane_1_tx <= 8'd0;
            enable    <= 1'b0;
            sym_start <= 1'b0;
            d_sel     <= IDLE_DSEL;
            gen_speed <= gen_speed_cfg;
            byte_cnt  <= 4'd0;
        end else begin
            // FLUSH, or a re-grant whose sources vanished: drain the encoder once.
            lane_0_tx <= 8'd0;
            lane_1_tx <= 8'd0;
            enable    <= 1'b1;
            sym_start <= 1'b0;
            byte_cnt  <= 4'd0;
            state     <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_enc_sym_scheduler.sv
// tb/tb_enc_sym_scheduler.sv - directed bench with a symbol-level reference model
module tb_enc_sym_scheduler;

    localparam int MAX_RUN = 4;

    logic       enc_clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_en = 1'b0;
    logic [1:0] gen_speed_cfg = 2'd0;
    logic       os_sym_avail = 1'b0;
    logic [3:0] os_type = 4'd0;
    logic [7:0] os_lane_0 = 8'd0;
    logic [7:0] os_lane_1 = 8'd0;
    logic       os_rd;
    logic       tl_sym_avail = 1'b0;
    logic [7:0] tl_lane_0 = 8'd0;
    logic [7:0] tl_lane_1 = 8'd0;
    logic       tl_rd;
    logic [7:0] lane_0_tx;
    logic [7:0] lane_1_tx;
    logic [3:0] d_sel;
    logic [1:0] gen_speed;
    logic       enable;
    logic       sym_start;
    logic       busy;

    always #5 enc_clk = ~enc_clk;

    enc_sym_scheduler #(.MAX_OS_RUN(MAX_RUN)) dut (
        .enc_clk      (enc_clk),
        .rst          (rst),
        .cfg_en       (cfg_en),
        .gen_speed_cfg(gen_speed_cfg),
        .os_sym_avail (os_sym_avail),
        .os_type      (os_type),
        .os_lane_0    (os_lane_0),
        .os_lane_1    (os_lane_1),
        .os_rd        (os_rd),
        .tl_sym_avail (tl_sym_avail),
        .tl_lane_0    (tl_lane_0),
        .tl_lane_1    (tl_lane_1),
        .tl_rd        (tl_rd),
        .lane_0_tx    (lane_0_tx),
        .lane_1_tx    (lane_1_tx),
        .d_sel        (d_sel),
        .gen_speed    (gen_speed),
        .enable       (enable),
        .sym_start    (sym_start),
        .busy         (busy)
    );

    typedef struct packed {
        logic [3:0] t;
        logic [7:0] l0;
        logic [7:0] l1;
    } ent_t;

    ent_t os_q[$];
    ent_t tl_q[$];
    int   sym_n = 8;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   chk_on = 1'b0;
    int   sizes[4] = '{1, 16, 8, 1};

    // Reference model: bytes left in the current symbol plus pending re-grant/flush.
    int         m_left = 0;
    int         m_run = 0;
    bit         m_cont = 1'b0;
    bit         m_flush = 1'b0;
    bit         m_tl = 1'b0;
    logic [1:0] m_gen = 2'd0;
    logic [3:0] m_dsel = 4'd9;
    logic [7:0] e_l0 = 8'd0;
    logic [7:0] e_l1 = 8'd0;
    logic [3:0] e_dsel = 4'd9;
    logic [1:0] e_gen = 2'd0;
    logic       e_en = 1'b0;
    logic       e_ss = 1'b0;
    bit         rec_os = 1'b0;
    bit         rec_tl = 1'b0;

    int         n_os_rd, n_tl_rd, n_ss, n_en, n_rise, n_badgen;
    logic       prev_en;
    logic [3:0] ss_dsel[$];
    logic [7:0] tx0[$];
    logic [3:0] exp4[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        os_sym_avail = (os_q.size() >= sym_n);
        tl_sym_avail = (tl_q.size() >= sym_n);
        if (os_q.size() > 0) {os_type, os_lane_0, os_lane_1} = os_q[0];
        else {os_type, os_lane_0, os_lane_1} = '0;
        if (tl_q.size() > 0) {tl_lane_0, tl_lane_1} = {tl_q[0].l0, tl_q[0].l1};
        else {tl_lane_0, tl_lane_1} = '0;
    endtask

    task automatic push_os(input int n, input logic [3:0] t, input logic [7:0] base);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i);
            os_q.push_back({t, b, ~b});
        end
    endtask

    task automatic push_tl(input int n, input logic [7:0] base);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i);
            tl_q.push_back({4'd0, b, ~b});
        end
    endtask

    task automatic clear_stats();
        n_os_rd = 0; n_tl_rd = 0; n_ss = 0; n_en = 0; n_rise = 0; n_badgen = 0;
        prev_en = 1'b0;
        ss_dsel.delete();
        tx0.delete();
    endtask

    task automatic model_step();
        bit idle, any, grant, flush_now, pop;
        idle = (m_left == 0) && !m_cont && !m_flush;
        any  = os_sym_avail || tl_sym_avail;
        if (chk_on) begin
            chk("lane_0_tx", lane_0_tx, e_l0);
            chk("lane_1_tx", lane_1_tx, e_l1);
            chk("d_sel", d_sel, e_dsel);
            chk("gen_speed", gen_speed, e_gen);
            chk("enable", enable, e_en);
            chk("sym_start", sym_start, e_ss);
            chk("busy", busy, !idle);
        end
        if (os_rd === 1'b1) n_os_rd++;
        if (tl_rd === 1'b1) n_tl_rd++;
        if (enable === 1'b1) begin
            n_en++;
            tx0.push_back(lane_0_tx);
            if (gen_speed !== 2'd2) n_badgen++;
            if (prev_en !== 1'b1) n_rise++;
        end
        prev_en = enable;
        if (sym_start === 1'b1) begin
            n_ss++;
            ss_dsel.push_back(d_sel);
        end

        pop = 1'b0;
        if (!rst) begin
            m_left = 0; m_run = 0; m_cont = 0; m_flush = 0; m_gen = 2'd0; m_dsel = 4'd9;
            e_l0 = 8'd0; e_l1 = 8'd0; e_dsel = 4'd9; e_gen = 2'd0; e_en = 0; e_ss = 0;
        end else begin
            flush_now = m_flush;
            m_flush   = 0;
            grant = (m_cont || (idle && cfg_en && gen_speed_cfg != 2'd3)) && any;
            if (!grant && m_cont) flush_now = 1;
            m_cont = 0;
            if (grant) begin
                if (idle) m_gen = gen_speed_cfg;
                m_tl = tl_sym_avail && (!os_sym_avail || m_run == MAX_RUN);
                if (m_tl) m_run = 0;
                else if (m_run < MAX_RUN) m_run++;
                m_dsel = m_tl ? 4'd8 : os_type;
                m_left = sizes[m_gen];
            end
            if (m_left > 0) begin
                pop = 1;
                m_left--;
                if (m_left == 0) begin
                    if (cfg_en && any) m_cont = 1;
                    else m_flush = 1;
                end
            end
            if (pop) begin
                e_l0 = m_tl ? tl_lane_0 : os_lane_0;
                e_l1 = m_tl ? tl_lane_1 : os_lane_1;
                e_en = 1; e_ss = grant; e_dsel = m_dsel;
            end else if (flush_now) begin
                e_l0 = 8'd0; e_l1 = 8'd0; e_en = 1; e_ss = 0;
            end else begin
                e_l0 = 8'd0; e_l1 = 8'd0; e_en = 0; e_ss = 0; e_dsel = 4'd9;
                m_gen = gen_speed_cfg;
            end
            e_gen = m_gen;
        end
        chk("os_rd", os_rd, pop && !m_tl);
        chk("tl_rd", tl_rd, pop && m_tl);
    endtask

    task automatic step();
        @(negedge enc_clk);
        model_step();
        rec_os = (os_rd === 1'b1);
        rec_tl = (tl_rd === 1'b1);
        @(posedge enc_clk);
        #1;
        if (rec_os && os_q.size() > 0) void'(os_q.pop_front());
        if (rec_tl && tl_q.size() > 0) void'(tl_q.pop_front());
        refresh();
    endtask

    task automatic drop_queues();
        os_q.delete();
        tl_q.delete();
        refresh();
    endtask

    initial begin
        exp4 = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd8, 4'd5, 4'd5, 4'd5, 4'd5, 4'd8};

        // Reset held with both sources ready
        rst = 0; cfg_en = 1; gen_speed_cfg = 2'd2; sym_n = 8;
        push_os(8, 4'd1, 8'h00); push_tl(8, 8'h40); refresh(); clear_stats();
        step(); chk_on = 1; step(); step();
        chk("rst_rd_count", n_os_rd + n_tl_rd, 0);
        chk("rst_enable", enable, 0);
        chk("rst_d_sel", d_sel, 9);
        chk("rst_lane_0", lane_0_tx, 0);
        drop_queues(); rst = 1;

        // gen2, TL only, two symbols
        clear_stats(); push_tl(16, 8'h10); refresh();
        repeat (24) step();
        chk("t2_tl_rd", n_tl_rd, 16);
        chk("t2_os_rd", n_os_rd, 0);
        chk("t2_sym_starts", n_ss, 2);
        if (ss_dsel.size() >= 2) begin
            chk("t2_dsel0", ss_dsel[0], 8);
            chk("t2_dsel1", ss_dsel[1], 8);
        end
        chk("t2_enable_cycles", n_en, 17);
        chk("t2_enable_runs", n_rise, 1);

        // gen3, OS only, type 3
        gen_speed_cfg = 2'd1; sym_n = 16; clear_stats();
        push_os(16, 4'd3, 8'h00); refresh();
        repeat (22) step();
        chk("t3_os_rd", n_os_rd, 16);
        chk("t3_sym_starts", n_ss, 1);
        chk("t3_tx_count", tx0.size(), 17);
        if (ss_dsel.size() >= 1) chk("t3_dsel", ss_dsel[0], 3);
        if (tx0.size() >= 17) begin
            for (int i = 0; i < 16; i++) chk("t3_byte", tx0[i], i);
            chk("t3_flush_byte", tx0[16], 0);
        end

        // Fairness with both sources continuously ready (gen4, one byte per symbol)
        rst = 0; cfg_en = 0; drop_queues(); step(); step(); rst = 1;
        gen_speed_cfg = 2'd0; sym_n = 1;
        push_os(40, 4'd5, 8'h20); push_tl(12, 8'h60); refresh(); clear_stats(); cfg_en = 1;
        repeat (10) step();
        cfg_en = 0;
        repeat (4) step();
        chk("t4_no_bubbles", n_rise, 1);
        if (ss_dsel.size() >= 10) begin
            for (int i = 0; i < 10; i++) chk("t4_grant", ss_dsel[i], exp4[i]);
        end else begin
            chk("t4_grant_count", ss_dsel.size(), 10);
        end
        drop_queues();

        // cfg_en dropped at byte 5, speed change at byte 3 of a gen2 symbol
        gen_speed_cfg = 2'd2; sym_n = 8; clear_stats();
        push_os(16, 4'd6, 8'h80); refresh(); cfg_en = 1;
        repeat (3) step();
        gen_speed_cfg = 2'd1;
        repeat (2) step();
        cfg_en = 0;
        repeat (10) step();
        chk("t5_os_rd", n_os_rd, 8);
        chk("t5_sym_starts", n_ss, 1);
        chk("t5_enable_cycles", n_en, 9);
        chk("t5_speed_held", n_badgen, 0);
        chk("t5_speed_idle", gen_speed, 1);
        drop_queues();

        // Reset at byte 9 of a gen3 symbol, then a clean restart
        sym_n = 16; clear_stats();
        push_os(32, 4'd2, 8'h00); refresh(); cfg_en = 1;
        repeat (9) step();
        rst = 0; os_q.delete(); push_os(16, 4'd7, 8'hA0); refresh();
        step();
        rst = 1;
        repeat (22) step();
        chk("t6_os_rd", n_os_rd, 25);
        chk("t6_sym_starts", n_ss, 2);
        if (tx0.size() >= 10) begin
            chk("t6_last_before_rst", tx0[8], 8);
            chk("t6_restart_byte", tx0[9], 8'hA0);
        end else begin
            chk("t6_tx_count", tx0.size(), 26);
        end
        if (ss_dsel.size() >= 2) chk("t6_restart_dsel", ss_dsel[1], 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
